alu_operand_sequencer: RTL and testbench
========================================

// Module: alu_operand_sequencer
// PURPOSE
//  Front-end stage that feeds the 3-bit ALU from board switches and a pushbutton.
//  - A debounced button steps an FSM through capture of operand A, operand B and the op select.
//  - After the op select is captured, the ALU's combinational result is registered.
//  - The registered result is held for display until the next button press.
// PARAMETERS
//  DB_COUNT   50000  consecutive stable cycles needed to accept a new button level (>=2)
//  DB_W       16     width of the debounce counter; must satisfy 2**DB_W > DB_COUNT
// PORTS
//  clk           in   1  system clock
//  rst           in   1  synchronous, active-high reset
//  sw            in   3  raw operand/select switches (sw[1:0] used as op select)
//  btn_next      in   1  raw pushbutton, asynchronous, bouncy
//  alu_q         in   4  combinational result returned from the ALU
//  a             out  3  registered operand A to the ALU
//  b             out  3  registered operand B to the ALU
//  sw_select     out  2  registered op select to the ALU (00 add, 01 sub, 10 eq, 11 shift)
//  result        out  4  registered ALU result
//  result_valid  out  1  high only while result matches the current a/b/sw_select
//  state_code    out  3  current FSM state, for LEDs
// BEHAVIOUR
//  Reset (sync, rst=1 at a clk edge):
//   - a, b, sw_select, result = 0; result_valid = 0; state = S_A.
//   - Synchronizer flops, debounced level and debounce counter = 0.
//   - Reset mid-sequence discards all partial captures.
//  Button path:
//   - btn_next passes through a 2-flop synchronizer to give btn_s.
//   - Debounce counter increments while btn_s != level and clears when they are equal.
//   - When the counter reaches DB_COUNT, level <= btn_s and the counter clears.
//   - press: internal pulse, high exactly 1 cycle, on the cycle after level goes 0->1.
//   - Release (1->0) generates no pulse.
//   - A held button gives one press only.
//   - Glitches shorter than DB_COUNT cycles give no press.
//  FSM (state_code value in brackets):
//   - S_A    [000]: on press, a <= sw, go to S_B.
//   - S_B    [001]: on press, b <= sw, go to S_OP.
//   - S_OP   [010]: on press, sw_select <= sw[1:0], go to S_EXEC.
//   - S_EXEC [011]: unconditionally, 1 cycle: result <= alu_q, result_valid <= 1, go to S_SHOW. Any press here is ignored.
//   - S_SHOW [100]: hold all outputs. On press, result_valid <= 0, go to S_A. result keeps its old value.
//   - Unused codes 101..111 go to S_A on the next cycle with result_valid <= 0.
//   - No press: the state and all registers hold.
//  Timing and widths:
//   - Latency from the press pulse in S_OP to result_valid=1 is 2 cycles.
//   - a, b and sw_select are stable for the whole S_EXEC cycle.
//   - Latency from a clean raw rise of btn_next to the register update is DB_COUNT+4 cycles (+/-1).
//   - alu_q is captured as-is (4 bits); no width conversion or sign handling here.
//   - sw is sampled only on the press cycle. It is not synchronized; the user holds it static.
//   - rst has priority over press in the same cycle.
// TESTING (bench uses DB_COUNT=4 and a behavioural ALU model on alu_q)
//  1. Reset: hold rst 2 cycles -> all outputs 0, state_code=000, result_valid=0.
//  2. Full add sequence:
//     - Press with sw=3, then sw=5, then sw=0 (clean presses, 20 cycles apart).
//     - Expect a=3, b=5, sw_select=00.
//     - 2 cycles after the third press: result=4'b1000, result_valid=1, state_code=100.
//  3. Bounce: toggle btn_next every 2 cycles for 12 cycles, then leave it low.
//     - Expect no press; state_code unchanged.
//  4. Held button: btn_next high for 100 cycles in S_A.
//     - Expect exactly one advance, to state_code=001.
//  5. Return path: press in S_SHOW.
//     - Expect result_valid=0 and state_code=000; result keeps 1000.
//     - Next sequence a=2, b=2, sel=10 (ALU model gives 0111) -> result=0111.
//  6. Reset mid-op: assert rst in S_OP after a=6, b=1 were captured.
//     - Expect a=0, b=0, state_code=000.
//     - A following press with sw=4 gives a=4.

Source files
------------

// File: rtl/alu_operand_sequencer.sv
// Front-end for the 3-bit ALU. A debounced pushbutton steps through capture of
// operand A, operand B and the op select, then registers and holds the ALU result.
module alu_operand_sequencer #(
  parameter int DB_COUNT = 50000,
  parameter int DB_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sw,
  input  logic       btn_next,
  input  logic [3:0] alu_q,
  output logic [2:0] a,
  output logic [2:0] b,
  output logic [1:0] sw_select,
  output logic [3:0] result,
  output logic       result_valid,
  output logic [2:0] state_code
);

  typedef enum logic [2:0] {
    S_A    = 3'b000,
    S_B    = 3'b001,
    S_OP   = 3'b010,
    S_EXEC = 3'b011,
    S_SHOW = 3'b100
  } state_t;

  localparam logic [DB_W-1:0] DB_MAX = DB_W'(DB_COUNT);

  logic            sync1, btn_s;
  logic            level, level_d;
  logic [DB_W-1:0] db_cnt;
  logic            press;
  state_t          state;

  // Two-flop synchronizer, then a level is only accepted after DB_COUNT
  // consecutive cycles of disagreement with the current debounced level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1   <= 1'b0;
      btn_s   <= 1'b0;
      level   <= 1'b0;
      level_d <= 1'b0;
      db_cnt  <= '0;
    end else begin
      sync1   <= btn_next;
      btn_s   <= sync1;
      level_d <= level;
      if (btn_s == level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_MAX) begin
        level  <= btn_s;
        db_cnt <= '0;
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
    end
  end

  // Rising edge of the debounced level only; release and hold give nothing.
  assign press = level & ~level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_A;
      a            <= '0;
      b            <= '0;
      sw_select    <= '0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      case (state)
        S_A: if (press) begin
          a     <= sw;
          state <= S_B;
        end
        S_B: if (press) begin
          b     <= sw;
          state <= S_OP;
        end
        S_OP: if (press) begin
          sw_select <= sw[1:0];
          state     <= S_EXEC;
        end
        // Operands have been stable for a full cycle, so alu_q has settled.
        S_EXEC: begin
          result       <= alu_q;
          result_valid <= 1'b1;
          state        <= S_SHOW;
        end
        S_SHOW: if (press) begin
          result_valid <= 1'b0;
          state        <= S_A;
        end
        default: begin
          result_valid <= 1'b0;
          state        <= S_A;
        end
      endcase
    end
  end

  assign state_code = state;

endmodule

// File: tb/tb_alu_operand_sequencer.sv
// Randomized self-checking bench: a stage-counting reference model predicts
// every output after each clean press, glitch or reset.
module tb_alu_operand_sequencer;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] sw;
  logic       btn_next;
  logic [3:0] alu_q;
  logic [2:0] a, b;
  logic [1:0] sw_select;
  logic [3:0] result;
  logic       result_valid;
  logic [2:0] state_code;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: stage is the expected state code (0,1,2,4).
  int         stage;
  logic [2:0] ma, mb;
  logic [1:0] msel;
  logic [3:0] mres;
  logic       mvalid;

  always #5 clk = ~clk;

  alu_operand_sequencer #(.DB_COUNT(DB), .DB_W(4)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn_next(btn_next), .alu_q(alu_q),
    .a(a), .b(b), .sw_select(sw_select), .result(result),
    .result_valid(result_valid), .state_code(state_code)
  );

  function automatic logic [3:0] alu_fn(input logic [2:0] x, input logic [2:0] y,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return 4'({1'b0, x} + {1'b0, y});
      2'b01:   return 4'({1'b0, x} - {1'b0, y});
      2'b10:   return (x == y) ? 4'b0111 : 4'b0000;
      default: return 4'({1'b0, x} << y[1:0]);
    endcase
  endfunction

  assign alu_q = alu_fn(a, b, sw_select);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".a"}, 32'(a), 32'(ma));
    chk({tag, ".b"}, 32'(b), 32'(mb));
    chk({tag, ".sel"}, 32'(sw_select), 32'(msel));
    chk({tag, ".result"}, 32'(result), 32'(mres));
    chk({tag, ".valid"}, 32'(result_valid), 32'(mvalid));
    chk({tag, ".state"}, 32'(state_code), 32'(stage));
  endtask

  task automatic model_reset();
    stage = 0; ma = '0; mb = '0; msel = '0; mres = '0; mvalid = 1'b0;
  endtask

  task automatic model_press(input logic [2:0] v);
    case (stage)
      0: begin ma = v; stage = 1; end
      1: begin mb = v; stage = 2; end
      2: begin msel = v[1:0]; mres = alu_fn(ma, mb, msel); mvalid = 1'b1; stage = 4; end
      default: begin mvalid = 1'b0; stage = 0; end
    endcase
  endtask

  task automatic do_reset();
    rst = 1'b1;
    btn_next = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Clean press: measure latency from raw rise to the state change; for the
  // op-select press also check the single EXEC cycle and the result timing.
  task automatic do_press(input logic [2:0] v);
    int prev = stage;
    int lat = -1;
    logic [3:0] exp_res;
    sw = v;
    btn_next = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (32'(state_code) != prev) begin
        lat = k;
        break;
      end
    end
    chk("press_latency", (lat >= DB + 3 && lat <= DB + 5) ? DB + 4 : lat, DB + 4);
    if (prev == 2) begin
      exp_res = alu_fn(ma, mb, v[1:0]);
      chk("exec_state", 32'(state_code), 3);
      chk("exec_valid", 32'(result_valid), 0);
      @(negedge clk);
      chk("show_state", 32'(state_code), 4);
      chk("show_valid", 32'(result_valid), 1);
      chk("show_result", 32'(result), 32'(exp_res));
    end
    model_press(v);
    repeat (15) @(negedge clk);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    sw = '0;
    btn_next = 1'b0;
    model_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_all("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Add sequence: 3 + 5 = 8
    do_press(3'd3);
    do_press(3'd5);
    do_press(3'd0);
    check_all("add_seq");
    chk("add_result", 32'(result), 32'b1000);

    // Bounce in S_SHOW must not advance
    for (int i = 0; i < 6; i++) begin
      btn_next = ~btn_next;
      repeat (2) @(negedge clk);
    end
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
    check_all("bounce");

    // Return to S_A; result is kept
    do_press(3'd0);
    check_all("return");
    chk("return_keep", 32'(result), 32'b1000);

    // Held button in S_A: exactly one advance
    sw = 3'd2;
    btn_next = 1'b1;
    repeat (100) @(negedge clk);
    model_press(3'd2);
    chk("held_state", 32'(state_code), 1);
    btn_next = 1'b0;
    repeat (20) @(negedge clk);
    check_all("held");

    do_press(3'd2);
    do_press(3'd2);
    check_all("eq_seq");
    chk("eq_result", 32'(result), 32'b0111);

    // Reset mid-sequence
    do_press(3'd0);
    do_press(3'd6);
    do_press(3'd1);
    check_all("pre_reset");
    do_reset();
    check_all("mid_reset");
    do_press(3'd4);
    check_all("after_reset");
    chk("after_reset_a", 32'(a), 4);

    // Randomized presses, short glitches and occasional resets
    for (int it = 0; it < 40; it++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70) begin
        do_press(3'($urandom_range(0, 7)));
        check_all("rnd_press");
      end else if (r < 92) begin
        sw = 3'($urandom_range(0, 7));
        btn_next = 1'b1;
        repeat ($urandom_range(1, DB - 1)) @(negedge clk);
        btn_next = 1'b0;
        repeat (10) @(negedge clk);
        check_all("rnd_glitch");
      end else begin
        do_reset();
        repeat (2) @(negedge clk);
        check_all("rnd_reset");
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
